if_fetch_unit: RTL and testbench

//  Instruction fetch stage that feeds the decode stage (pc/inst/jump_enable interface).

---
 rtl/if_fetch_unit.sv | 206 ++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage. Holds the fetch PC, issues one 32-bit word fetch at
// a time over a req/ack handshake, statically predicts the next PC and buffers
// fetched {pc, inst, pred} entries in an in-order queue for decode. A redirect
// from execute/commit flushes the queue and retargets the PC.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   rdy             global enable; 0 freezes every register
//   mem_req_o       fetch request, held until mem_ack_i
//   mem_addr_o      fetch address, stable while mem_req_o is high
//   mem_ack_i       one-cycle acknowledge, mem_data_i valid in that cycle
//   mem_data_i      fetched instruction word
//   redirect_i      one-cycle PC correction pulse
//   redirect_pc_i   corrected PC
//   id_stall_i      decode cannot accept an entry this cycle
//   valid_o         head entry valid
//   pc_o, inst_o    head entry PC and instruction
//   jump_enable_o   head entry predicted taken
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int          QUEUE_DEPTH   = 4,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter bit          PRED_BACKWARD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_stall_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        jump_enable_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // Static prediction: returns {pred, next_pc}. JAL always taken, backward
    // conditional branches taken when enabled, everything else falls through.
    function automatic logic [32:0] predict_next(input logic [31:0] pc,
                                                 input logic [31:0] inst);
        logic [31:0] jal_imm;
        logic [31:0] br_imm;
        logic [32:0] res;
        jal_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        br_imm  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        if (inst[6:0] == 7'b1101111) begin
            res = {1'b1, pc + jal_imm};
        end else if ((inst[6:0] == 7'b1100011) && inst[31] && (PRED_BACKWARD != 1'b0)) begin
            res = {1'b1, pc + br_imm};
        end else begin
            res = {1'b0, pc + 32'd4};
        end
        return res;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [31:0]        pc_r;
    logic               mem_req_r;
    logic [31:0]        mem_addr_r;
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;
    logic [31:0]        q_pc_r   [QUEUE_DEPTH];
    logic [31:0]        q_inst_r [QUEUE_DEPTH];
    logic               q_pred_r [QUEUE_DEPTH];

    logic               issue_s;
    logic               enq_s;
    logic               drop_req_s;
    logic               valid_s;
    logic               deq_s;
    logic [32:0]        pred_s;

    assign pred_s  = predict_next(pc_r, mem_data_i);
    // A redirect hides the head in the same cycle so decode never consumes a
    // wrong-path entry that is about to be flushed.
    assign valid_s = (count_r != {CNT_W{1'b0}}) & ~redirect_i;
    assign deq_s   = valid_s & ~id_stall_i;

    assign valid_o       = valid_s;
    assign pc_o          = q_pc_r[head_r];
    assign inst_o        = q_inst_r[head_r];
    assign jump_enable_o = q_pred_r[head_r];
    assign mem_req_o     = mem_req_r;
    assign mem_addr_o    = mem_addr_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else if (rdy) begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and handshake control
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        enq_s       = 1'b0;
        drop_req_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A slot is reserved at issue time, so the ack can always enqueue.
                if (!redirect_i && (count_r < CNT_W'(QUEUE_DEPTH))) begin
                    issue_s     = 1'b1;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    if (mem_ack_i) begin
                        drop_req_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DISCARD;
                    end
                end else if (mem_ack_i) begin
                    enq_s       = 1'b1;
                    drop_req_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                // The stale fetch must still complete before a new one is issued.
                if (mem_ack_i) begin
                    drop_req_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DISCARD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // PC, request outputs and queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'h0000_0000;
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else if (rdy) begin
            if (redirect_i) begin
                pc_r    <= redirect_pc_i;
                head_r  <= {PTR_W{1'b0}};
                tail_r  <= {PTR_W{1'b0}};
                count_r <= {CNT_W{1'b0}};
            end else begin
                if (enq_s) begin
                    pc_r   <= pred_s[31:0];
                    tail_r <= tail_r + PTR_W'(1);
                end
                if (deq_s) begin
                    head_r <= head_r + PTR_W'(1);
                end
                case ({enq_s, deq_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
            if (issue_s) begin
                mem_req_r  <= 1'b1;
                mem_addr_r <= pc_r;
            end else if (drop_req_s) begin
                mem_req_r  <= 1'b0;
            end
        end
    end

    // Queue storage; contents are only meaningful below count_r
    always_ff @(posedge clk) begin
        if (rdy && enq_s) begin
            q_pc_r[tail_r]   <= pc_r;
            q_inst_r[tail_r] <= mem_data_i;
            q_pred_r[tail_r] <= pred_s[32];
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, rdy, stall;
    logic        mem_ack, redirect;
    logic [31:0] mem_data, redirect_pc;
    logic        mem_req, valid, je;
    logic [31:0] mem_addr, pc_out, inst_out;

    logic        nb_ack, nb_redirect;
    logic [31:0] nb_data, nb_redirect_pc;
    logic        nb_req, nb_valid, nb_je;
    logic [31:0] nb_addr, nb_pc, nb_inst;

    int tests_run = 0;
    int fails     = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } entry_t;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_ack_i(mem_ack), .mem_data_i(mem_data),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .id_stall_i(stall),
        .valid_o(valid), .pc_o(pc_out), .inst_o(inst_out), .jump_enable_o(je)
    );

    if_fetch_unit #(.PRED_BACKWARD(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_req_o(nb_req), .mem_addr_o(nb_addr),
        .mem_ack_i(nb_ack), .mem_data_i(nb_data),
        .redirect_i(nb_redirect), .redirect_pc_i(nb_redirect_pc),
        .id_stall_i(stall),
        .valid_o(nb_valid), .pc_o(nb_pc), .inst_o(nb_inst), .jump_enable_o(nb_je)
    );

    // Reference prediction from the ISA immediate definitions, in modular arithmetic.
    function automatic void ref_predict(input logic [31:0] pc, input logic [31:0] d,
                                        input bit back_en,
                                        output logic [31:0] npc, output logic pred);
        logic [31:0] off;
        if (d[6:0] == 7'b1101111) begin
            off = (d[31] ? 32'hFFF0_0000 : 32'h0) + 32'(d[19:12]) * 32'd4096
                + 32'(d[20]) * 32'd2048 + 32'(d[30:21]) * 32'd2;
            pred = 1'b1;
        end else if (d[6:0] == 7'b1100011 && d[31] && back_en) begin
            off = 32'hFFFF_F000 + 32'(d[7]) * 32'd2048 + 32'(d[30:25]) * 32'd32
                + 32'(d[11:8]) * 32'd2;
            pred = 1'b1;
        end else begin
            off  = 32'd4;
            pred = 1'b0;
        end
        npc = pc + off;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 4))
            0:       v[6:0] = 7'b1101111;
            1:       begin v[6:0] = 7'b1100011; v[31] = 1'b1; end
            2:       begin v[6:0] = 7'b1100011; v[31] = 1'b0; end
            3:       v[6:0] = 7'b1100111;
            default: v[6:0] = 7'b0010011;
        endcase
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        rdy = 1'b1; stall = 1'b0; mem_ack = 1'b0; mem_data = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0;
        nb_ack = 1'b0; nb_data = 32'h0; nb_redirect = 1'b0; nb_redirect_pc = 32'h0;
    endtask

    task automatic do_reset();
        init_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Memory responder: waits (bounded) for a request, acks it with d for one cycle.
    task automatic serve(input bit sel, input logic [31:0] d,
                         output logic [31:0] addr, output bit ok);
        ok   = 1'b0;
        addr = 32'h0;
        for (int i = 0; i < 20; i++) begin
            if (sel ? nb_req : mem_req) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (ok) begin
            addr = sel ? nb_addr : mem_addr;
            if (sel) begin nb_ack = 1'b1; nb_data = d; end
            else     begin mem_ack = 1'b1; mem_data = d; end
            cyc();
            nb_ack  = 1'b0;
            mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        init_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        tests_run++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", mem_req); end
        tests_run++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        tests_run++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        logic [31:0] a; bit ok;
        do_reset();
        stall = 1'b1;
        serve(1'b0, 32'h0010_0093, a, ok);
        tests_run++; if (!ok || a !== 32'h0) begin fails++; $display("FAIL first_addr: got %h ok=%0d want 0", a, ok); end
        tests_run++; if ({valid, pc_out, inst_out, je} !== {1'b1, 32'h0, 32'h0010_0093, 1'b0}) begin
            fails++; $display("FAIL first_entry: got v=%b pc=%h inst=%h je=%b want v=1 pc=0 inst=00100093 je=0", valid, pc_out, inst_out, je); end
        serve(1'b0, 32'h0000_0013, a, ok);
        tests_run++; if (!ok || a !== 32'h4) begin fails++; $display("FAIL second_addr: got %h want 4", a); end
    endtask

    task automatic test_jal();
        logic [31:0] a; bit ok;
        do_reset();
        stall = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h8;
        cyc();
        redirect = 1'b0;
        serve(1'b0, 32'h0100_006F, a, ok);
        tests_run++; if (!ok || a !== 32'h8) begin fails++; $display("FAIL jal_addr: got %h want 8", a); end
        tests_run++; if ({valid, pc_out, je} !== {1'b1, 32'h8, 1'b1}) begin
            fails++; $display("FAIL jal_entry: got v=%b pc=%h je=%b want v=1 pc=8 je=1", valid, pc_out, je); end
        serve(1'b0, 32'h0000_0013, a, ok);
        tests_run++; if (!ok || a !== 32'h18) begin fails++; $display("FAIL jal_target: got %h want 18", a); end
    endtask

    task automatic test_branch_backward();
        logic [31:0] a; bit ok;
        do_reset();
        stall = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h20;
        nb_redirect = 1'b1; nb_redirect_pc = 32'h20;
        cyc();
        redirect = 1'b0; nb_redirect = 1'b0;
        serve(1'b0, 32'hFE00_0CE3, a, ok);
        tests_run++; if (!ok || a !== 32'h20) begin fails++; $display("FAIL br_addr: got %h want 20", a); end
        tests_run++; if ({valid, pc_out, je} !== {1'b1, 32'h20, 1'b1}) begin
            fails++; $display("FAIL br_entry: got v=%b pc=%h je=%b want v=1 pc=20 je=1", valid, pc_out, je); end
        serve(1'b1, 32'hFE00_0CE3, a, ok);
        tests_run++; if (!ok || a !== 32'h20) begin fails++; $display("FAIL nb_addr: got %h want 20", a); end
        tests_run++; if ({nb_valid, nb_pc, nb_inst, nb_je} !== {1'b1, 32'h20, 32'hFE00_0CE3, 1'b0}) begin
            fails++; $display("FAIL nb_entry: got v=%b pc=%h inst=%h je=%b want v=1 pc=20 inst=fe000ce3 je=0", nb_valid, nb_pc, nb_inst, nb_je); end
        serve(1'b0, 32'h0000_0013, a, ok);
        tests_run++; if (!ok || a !== 32'h18) begin fails++; $display("FAIL br_target: got %h want 18", a); end
        serve(1'b1, 32'h0000_0013, a, ok);
        tests_run++; if (!ok || a !== 32'h24) begin fails++; $display("FAIL nb_target: got %h want 24", a); end
    endtask

    task automatic test_stall_full();
        logic [31:0] a; bit ok; int seen;
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(1'b0, 32'h0000_0013, a, ok);
            tests_run++; if (!ok || a !== 32'(4 * i)) begin fails++; $display("FAIL fill_addr%0d: got %h want %h", i, a, 32'(4 * i)); end
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (mem_req) seen++;
        end
        tests_run++; if (seen != 0) begin fails++; $display("FAIL full_no_req: got %0d req cycles want 0", seen); end
        stall = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests_run++; if ({valid, pc_out} !== {1'b1, 32'(4 * i)}) begin
                fails++; $display("FAIL drain%0d: got v=%b pc=%h want v=1 pc=%h", i, valid, pc_out, 32'(4 * i)); end
            cyc();
        end
        serve(1'b0, 32'h0000_0013, a, ok);
        tests_run++; if (!ok || a !== 32'h10) begin fails++; $display("FAIL resume_addr: got %h want 10", a); end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] a; bit ok;
        do_reset();
        stall = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hC;
        cyc();
        redirect = 1'b0;
        serve(1'b0, 32'h0000_0013, a, ok);
        serve(1'b0, 32'h0000_0013, a, ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_req) ok = 1'b1;
            else cyc();
        end
        tests_run++; if (!ok || mem_addr !== 32'h14) begin fails++; $display("FAIL rw_wait_addr: got %h want 14", mem_addr); end
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        tests_run++; if (valid !== 1'b0) begin fails++; $display("FAIL rw_valid_same: got %b want 0", valid); end
        cyc();
        redirect = 1'b0;
        tests_run++; if ({valid, mem_req} !== 2'b01) begin fails++; $display("FAIL rw_discard: got v=%b req=%b want v=0 req=1", valid, mem_req); end
        serve(1'b0, 32'hDEAD_BEEF, a, ok);
        tests_run++; if (!ok || a !== 32'h14 || valid !== 1'b0) begin fails++; $display("FAIL rw_dropped: got addr=%h v=%b want addr=14 v=0", a, valid); end
        serve(1'b0, 32'h0000_0013, a, ok);
        tests_run++; if (!ok || a !== 32'h100) begin fails++; $display("FAIL rw_new_addr: got %h want 100", a); end
        tests_run++; if ({valid, pc_out} !== {1'b1, 32'h100}) begin fails++; $display("FAIL rw_entry: got v=%b pc=%h want v=1 pc=100", valid, pc_out); end
    endtask

    task automatic test_redirect_ack_and_freeze();
        logic [31:0] a; bit ok;
        do_reset();
        stall = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_req) ok = 1'b1;
            else cyc();
        end
        mem_ack = 1'b1; mem_data = 32'h0100_006F;
        redirect = 1'b1; redirect_pc = 32'h200;
        cyc();
        mem_ack = 1'b0; redirect = 1'b0;
        tests_run++; if ({valid, mem_req} !== 2'b00) begin fails++; $display("FAIL ra_dropped: got v=%b req=%b want 00", valid, mem_req); end
        serve(1'b0, 32'h0000_0013, a, ok);
        tests_run++; if (!ok || a !== 32'h200) begin fails++; $display("FAIL ra_addr: got %h want 200", a); end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_req) ok = 1'b1;
            else cyc();
        end
        rdy = 1'b0; stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            tests_run++; if ({mem_req, mem_addr, valid, pc_out} !== {1'b1, 32'h204, 1'b1, 32'h200}) begin
                fails++; $display("FAIL freeze%0d: got req=%b addr=%h v=%b pc=%h want 1/204/1/200", i, mem_req, mem_addr, valid, pc_out); end
        end
        rdy = 1'b1;
        cyc();
        tests_run++; if (valid !== 1'b0) begin fails++; $display("FAIL unfreeze_deq: got v=%b want 0", valid); end
        serve(1'b0, 32'h0000_0013, a, ok);
        tests_run++; if (!ok || a !== 32'h204 || pc_out !== 32'h204 || valid !== 1'b1) begin
            fails++; $display("FAIL unfreeze_fetch: got addr=%h pc=%h v=%b want 204/204/1", a, pc_out, valid); end
    endtask

    task automatic test_random();
        entry_t      mq[$];
        entry_t      e;
        logic [31:0] model_pc, hold_addr, npc;
        logic        pred, exp_valid, prev_req, discarding;
        int          prev_size;
        do_reset();
        model_pc = 32'h0; prev_req = 1'b0; discarding = 1'b0; prev_size = 0; hold_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            rdy         = ($urandom_range(0, 7) != 0);
            stall       = ($urandom_range(0, 2) == 0);
            redirect    = rdy && ($urandom_range(0, 29) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            mem_ack     = rdy && mem_req && ($urandom_range(0, 2) == 0);
            mem_data    = gen_inst();
            #1;
            exp_valid = (mq.size() != 0) && !redirect;
            tests_run++; if (valid !== exp_valid) begin fails++; $display("FAIL rnd_valid c%0d: got %b want %b", c, valid, exp_valid); end
            if (exp_valid) begin
                tests_run++; if ({pc_out, inst_out, je} !== {mq[0].pc, mq[0].inst, mq[0].pred}) begin
                    fails++; $display("FAIL rnd_head c%0d: got pc=%h inst=%h je=%b want pc=%h inst=%h je=%b",
                                      c, pc_out, inst_out, je, mq[0].pc, mq[0].inst, mq[0].pred); end
            end
            if (mem_req && !prev_req) begin
                tests_run++; if (mem_addr !== model_pc || prev_size >= 4) begin
                    fails++; $display("FAIL rnd_issue c%0d: got addr=%h qsize=%0d want addr=%h qsize<4", c, mem_addr, prev_size, model_pc); end
            end else if (mem_req) begin
                tests_run++; if (mem_addr !== hold_addr) begin fails++; $display("FAIL rnd_hold c%0d: got %h want %h", c, mem_addr, hold_addr); end
            end
            hold_addr = mem_addr;
            prev_req  = mem_req;
            prev_size = mq.size();
            if (rdy) begin
                if (redirect) begin
                    mq.delete();
                    model_pc   = redirect_pc;
                    discarding = mem_req && !mem_ack;
                end else begin
                    if (exp_valid && !stall) void'(mq.pop_front());
                    if (mem_ack) begin
                        if (discarding) begin
                            discarding = 1'b0;
                        end else begin
                            ref_predict(model_pc, mem_data, 1'b1, npc, pred);
                            e.pc = model_pc; e.inst = mem_data; e.pred = pred;
                            mq.push_back(e);
                            model_pc = npc;
                        end
                    end
                end
            end
            cyc();
        end
        init_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_jal();
        test_branch_backward();
        test_stall_full();
        test_redirect_wait();
        test_redirect_ack_and_freeze();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
